// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch stage: owns the PC, drives instruction memory, and
// loads the IF/ID register with redirect squash, stall hold and TRAP halt.
module dlx_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter logic [5:0]  TRAP_OPCODE = 6'b010001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_cs,
  output logic        imem_oe,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  input  logic [0:31] imem_dout,
  output logic [0:31] if_instr,
  output logic [31:0] if_npc,
  output logic        if_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [0:31] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_inc;
  logic        is_trap;
  logic        unused_rpc_lsbs;

  assign pc_inc  = pc_q + 32'd4;
  assign is_trap = (imem_dout[0:5] == TRAP_OPCODE);
  // Redirect targets are word-aligned; the byte offset is dropped.
  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (redirect) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_dout;
          npc_d   = pc_inc;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 32'd1;
          // A TRAP is delivered to decode but the PC parks on it.
          if (is_trap) state_d = HALT;
          else         pc_d    = pc_inc;
        end
      end
      HALT: begin
        if (!stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      npc_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_cs     = (state_q == RUN);
  assign imem_oe     = (state_q == RUN);
  assign imem_we     = 1'b0;
  assign if_instr    = instr_q;
  assign if_npc      = npc_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_dlx_fetch_stage.sv
// Scoreboarded bench for dlx_fetch_stage: directed scenarios then random traffic,
// checked against an abstract fetch model over a small word-addressed memory.
module tb_dlx_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_cs, imem_oe, imem_we;
  logic [31:0] imem_addr;
  logic [0:31] imem_dout;
  logic [0:31] if_instr;
  logic [31:0] if_npc;
  logic        if_valid, halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // reference state
  logic [31:0] m_pc, m_instr, m_npc, m_cnt;
  logic        m_valid, m_halt;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr[9:2]];

  dlx_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_cs(imem_cs), .imem_oe(imem_oe),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .if_instr(if_instr), .if_npc(if_npc), .if_valid(if_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs (called at negedge), advance the model, queue the
  // expected post-edge state, then wait for the next negedge.
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    logic [31:0] w;
    exp_t e;
    reset = r; stall = s; redirect = rd; redirect_pc = rpc;
    w = mem[m_pc[9:2]];
    if (r) begin
      m_pc = 32'h0; m_halt = 1'b0; m_instr = NOP; m_npc = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    end else if (m_halt) begin
      if (!s) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (rd) begin
      m_pc = rpc & ~32'h3; m_instr = NOP; m_valid = 1'b0;
    end else if (!s) begin
      m_instr = w; m_npc = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      if (w[31:26] == 6'b010001) m_halt = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.npc = m_npc;
    e.valid = m_valid; e.halt = m_halt; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("imem_addr",   imem_addr,   e.pc);
      chk("if_instr",    if_instr,    e.instr);
      chk("if_npc",      if_npc,      e.npc);
      chk("if_valid",    {31'd0, if_valid}, {31'd0, e.valid});
      chk("halted",      {31'd0, halted},   {31'd0, e.halt});
      chk("fetch_count", fetch_count, e.cnt);
      chk("imem_cs",     {31'd0, imem_cs},  {31'd0, !e.halt});
      chk("imem_oe",     {31'd0, imem_oe},  {31'd0, !e.halt});
      chk("imem_we",     {31'd0, imem_we},  32'd0);
    end
  end

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b010001) w[31] = 1'b1;
      if ($urandom_range(0, 15) == 0) w[31:26] = 6'b010001;
      mem[i] = w;
    end
    mem[0]   = 32'h2001AAAA;
    mem[1]   = 32'h90030080;
    mem[2]   = 32'hA0030081;
    mem[3]   = 32'h20000000;
    mem[4]   = 32'h44000000;
    mem[8]   = 32'h20000008;
    mem[16]  = 32'h20000010;
    mem[32]  = 32'hF0F077F0;
    mem[255] = 32'h200000FF;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    m_pc = 0; m_instr = NOP; m_npc = 0; m_cnt = 0; m_valid = 0; m_halt = 0;
    @(negedge clk);

    cyc(1, 0, 0, 0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0);
    chk("e1_instr", if_instr, 32'h2001AAAA);
    chk("e1_addr", imem_addr, 32'h4);
    repeat (3) cyc(0, 1, 0, 0);
    chk("stall_addr", imem_addr, 32'h4);
    chk("stall_cnt", fetch_count, 32'd1);
    cyc(0, 0, 0, 0);
    chk("e2_instr", if_instr, 32'h90030080);
    cyc(0, 0, 0, 0);
    chk("e3_instr", if_instr, 32'hA0030081);
    chk("e3_cnt", fetch_count, 32'd3);
    cyc(0, 1, 1, 32'h83);
    chk("redir_addr", imem_addr, 32'h80);
    chk("redir_valid", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("redir_instr", if_instr, 32'hF0F077F0);
    chk("redir_npc", if_npc, 32'h84);
    cyc(0, 0, 1, 32'h10);
    cyc(0, 0, 0, 0);
    chk("trap_instr", if_instr, 32'h44000000);
    chk("trap_halted", {31'd0, halted}, 32'd1);
    chk("trap_cs", {31'd0, imem_cs}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("halt_valid", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 1, 32'h40);
    chk("halt_redir", imem_addr, 32'h10);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 32'h10);
    cyc(0, 0, 1, 32'h20);
    chk("trapredir_halted", {31'd0, halted}, 32'd0);
    chk("trapredir_addr", imem_addr, 32'h20);
    cyc(0, 0, 1, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0);
    chk("wrap_npc", if_npc, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(1, 1, 0, 0);
    chk("rst_stall_cnt", fetch_count, 32'd0);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFFFF00 | $urandom_range(0, 255)
                                      : $urandom_range(0, 1023);
      cyc($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, t);
    end

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlx_fetch_stage.md
Name: dlx_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the five-stage DLX pipeline.
- Sits directly upstream of the instruction memory (`sram`): drives its address and control strobes, and captures the returned word into the IF/ID pipeline register for decode.
- Owns the PC, sequential increment, branch/jump redirect with squash, pipeline stall, and TRAP-triggered halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word placed in IF/ID on squash or halt.
- TRAP_OPCODE, 6'b010001, opcode (bits [0:5]) that halts fetch.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard stall from ID/EX; hold PC and IF/ID
- redirect  input  1  taken branch/jump resolved in ID
- redirect_pc  input  32  target PC for redirect
- imem_cs  output  1  instruction memory chip select
- imem_oe  output  1  instruction memory output enable
- imem_we  output  1  instruction memory write enable; constant 0
- imem_addr  output  32  fetch address; equals the PC register
- imem_dout  input  [0:31]  fetched word; combinational on imem_addr; bit 0 = MSB
- if_instr  output  [0:31]  IF/ID instruction register
- if_npc  output  32  IF/ID next-PC (fetch PC + 4)
- if_valid  output  1  IF/ID holds a real instruction
- halted  output  1  fetch halted by TRAP
- fetch_count  output  32  count of instructions delivered valid to IF/ID

Behaviour:
- Reset, synchronous and active-high, dominates all other inputs:
  - pc = RESET_PC, state = RUN
  - if_instr = NOP_INSTR, if_npc = 0, if_valid = 0
  - halted = 0, fetch_count = 0
- Combinational outputs:
  - imem_addr = pc
  - imem_cs = imem_oe = (state == RUN)
  - imem_we = 0 always
- Latency: the word at pc appears on if_instr one clock edge after pc is presented.
- States: RUN, HALT. HALT is left only by reset.
- Per-edge priority in RUN (first matching rule applies):
  1. redirect=1, regardless of stall:
     - pc <= {redirect_pc[31:2], 2'b00}
     - if_instr <= NOP_INSTR, if_valid <= 0, if_npc unchanged
     - fetch_count unchanged
     - a TRAP word on imem_dout this cycle is ignored; state stays RUN
  2. stall=1: pc, IF/ID and fetch_count all hold.
  3. imem_dout[0:5] == TRAP_OPCODE:
     - if_instr <= imem_dout, if_npc <= pc+4, if_valid <= 1
     - fetch_count += 1
     - pc holds
     - state <= HALT, halted <= 1
  4. Otherwise:
     - if_instr <= imem_dout, if_npc <= pc+4, if_valid <= 1
     - pc <= pc+4
     - fetch_count += 1
- HALT behaviour:
  - redirect ignored
  - stall=1: IF/ID holds, so the TRAP stays visible to decode
  - stall=0: if_instr <= NOP_INSTR, if_valid <= 0
  - pc and fetch_count frozen; halted stays 1
- Arithmetic:
  - pc+4 is modulo 2^32, so 32'hFFFF_FFFC advances to 0
  - fetch_count wraps modulo 2^32
- Reset asserted mid-stall or mid-redirect: reset values apply on that edge; the next edge fetches from RESET_PC.

Test Plan:
- Reset, then memory {0x0: 0x2001AAAA, 0x4: 0x90030080, 0x8: 0xA0030081} with stall=0:
  - edge 1 -> if_instr=0x2001AAAA, if_npc=4, if_valid=1, imem_addr=4
  - edge 3 -> if_instr=0xA0030081, if_npc=0xC, fetch_count=3
- stall=1 for 3 cycles after edge 1:
  - imem_addr stays 4, if_instr stays 0x2001AAAA, fetch_count stays 1
  - stall released -> next edge if_instr=0x90030080
- redirect=1 with redirect_pc=0x83 while stall=1:
  - next edge pc=0x80, if_valid=0, if_instr=NOP_INSTR, fetch_count unchanged
  - following edge if_instr=0xF0F077F0, if_npc=0x84
- TRAP word 0x44000000 at 0x10, fetched in sequence:
  - next edge if_instr=0x44000000, if_valid=1, halted=1, imem_cs=0, pc stays 0x10
  - following edge if_valid=0
  - a later redirect=1 leaves pc=0x10
- TRAP on imem_dout with redirect=1 on the same edge -> halted=0, pc=redirect target, if_valid=0.
- Wrap-around: redirect_pc=0xFFFFFFFC -> after the fetch, if_npc=0 and imem_addr=0. Then reset asserted with stall=1 -> if_valid=0, pc=RESET_PC, fetch_count=0.
